// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus a multi-cycle shift-add multiplier,
// feeding a registered EX/MEM output bank that honours memory-stage stalls.
//
//   state | meaning
//   IDLE  | accepting operations; single-cycle results load the output register
//   MUL   | one shift-add step per cycle, N steps total
//   DONE  | product ready; waits for memStall low before loading the output
module execute_stage #(
  parameter int N    = 32,
  parameter int RD_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inValid,
  input  logic [3:0]      aluOp,
  input  logic [N-1:0]    srcA,
  input  logic [N-1:0]    srcB,
  input  logic [N-1:0]    WDIn,
  input  logic [RD_W-1:0] RdIn,
  input  logic            memWriteIn,
  input  logic            memPixWriteIn,
  input  logic            memStall,
  output logic            busy,
  output logic [N-1:0]    aluResult,
  output logic [N-1:0]    WD,
  output logic [RD_W-1:0] Rd,
  output logic            memWrite,
  output logic            memPixWrite,
  output logic            outValid
);

  localparam int SHW = $clog2(N);
  localparam int CW  = SHW + 1;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_OR    = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_PASSB = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t            state, state_next;
  logic [CW-1:0]     cnt;
  logic [N-1:0]      mcand, mplier, prod;
  logic [N-1:0]      lat_wd;
  logic [RD_W-1:0]   lat_rd;
  logic              lat_mw, lat_mpw;
  logic [N-1:0]      alu_res;
  logic [SHW-1:0]    shamt;
  logic              accept, start_mul, mul_last;

  assign busy      = (state != IDLE) | memStall;
  assign accept    = inValid & ~busy;
  assign start_mul = accept & (aluOp == OP_MUL);
  assign mul_last  = (state == MUL) && (cnt == CW'(N - 1));
  assign shamt     = srcB[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (aluOp)
      OP_ADD:   alu_res = srcA + srcB;
      OP_SUB:   alu_res = srcA - srcB;
      OP_AND:   alu_res = srcA & srcB;
      OP_OR:    alu_res = srcA | srcB;
      OP_XOR:   alu_res = srcA ^ srcB;
      OP_SLL:   alu_res = srcA << shamt;
      OP_SRL:   alu_res = srcA >> shamt;
      OP_SRA:   alu_res = N'($signed(srcA) >>> shamt);
      OP_SLT:   alu_res = {{(N-1){1'b0}}, ($signed(srcA) < $signed(srcB))};
      OP_PASSB: alu_res = srcB;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_mul) state_next = MUL;
      MUL:     if (mul_last) state_next = DONE;
      DONE:    if (!memStall) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      mcand       <= '0;
      mplier      <= '0;
      prod        <= '0;
      lat_wd      <= '0;
      lat_rd      <= '0;
      lat_mw      <= 1'b0;
      lat_mpw     <= 1'b0;
      aluResult   <= '0;
      WD          <= '0;
      Rd          <= '0;
      memWrite    <= 1'b0;
      memPixWrite <= 1'b0;
      outValid    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_mul) begin
            mcand    <= srcA;
            mplier   <= srcB;
            prod     <= '0;
            cnt      <= '0;
            lat_wd   <= WDIn;
            lat_rd   <= RdIn;
            lat_mw   <= memWriteIn;
            lat_mpw  <= memPixWriteIn;
            outValid <= 1'b0;
          end else if (accept) begin
            aluResult   <= alu_res;
            WD          <= WDIn;
            Rd          <= RdIn;
            memWrite    <= memWriteIn;
            memPixWrite <= memPixWriteIn;
            outValid    <= 1'b1;
          end else if (!memStall) begin
            outValid <= 1'b0;
          end
        end
        // Multiplier keeps stepping under memStall; only DONE waits on it.
        MUL: begin
          if (mplier[0]) prod <= prod + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
        end
        DONE: begin
          if (!memStall) begin
            aluResult   <= prod;
            WD          <= lat_wd;
            Rd          <= lat_rd;
            memWrite    <= lat_mw;
            memPixWrite <= lat_mpw;
            outValid    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: expected EX/MEM fields are queued at issue
// and checked whenever a fresh output is loaded (an unstalled edge with outValid).
module tb_execute_stage;
  localparam int N    = 32;
  localparam int RD_W = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            inValid;
  logic [3:0]      aluOp;
  logic [N-1:0]    srcA, srcB, WDIn;
  logic [RD_W-1:0] RdIn;
  logic            memWriteIn, memPixWriteIn, memStall;
  logic            busy;
  logic [N-1:0]    aluResult, WD;
  logic [RD_W-1:0] Rd;
  logic            memWrite, memPixWrite, outValid;

  execute_stage #(.N(N), .RD_W(RD_W)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .aluOp(aluOp),
    .srcA(srcA), .srcB(srcB), .WDIn(WDIn), .RdIn(RdIn),
    .memWriteIn(memWriteIn), .memPixWriteIn(memPixWriteIn),
    .memStall(memStall), .busy(busy), .aluResult(aluResult),
    .WD(WD), .Rd(Rd), .memWrite(memWrite), .memPixWrite(memPixWrite),
    .outValid(outValid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]    res;
    logic [N-1:0]    wd;
    logic [RD_W-1:0] rd;
    logic            mw;
    logic            mpw;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic out_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: edge, sample 1ns later, score a fresh output, return at negedge.
  task automatic cycle();
    logic st;
    exp_t e;
    @(posedge clk);
    st = memStall;
    #1;
    out_seen = 1'b0;
    if (!st && outValid === 1'b1) begin
      out_seen = 1'b1;
      if (sb.size() == 0) begin
        chk("unexpected_output", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("result", aluResult, e.res);
        chk("wd", WD, e.wd);
        chk("rd", Rd, e.rd);
        chk("mem_write", memWrite, e.mw);
        chk("mem_pix_write", memPixWrite, e.mpw);
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [N-1:0] model(input logic [3:0] op, input logic [N-1:0] a,
                                         input logic [N-1:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return N'($signed(a) >>> sh);
      4'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:  return b;
      4'd10: return N'(a * b);
      default: return '0;
    endcase
  endfunction

  task automatic issue(input logic [3:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] wd, input logic [RD_W-1:0] rd,
                       input logic mw, input logic mpw, input logic [N-1:0] res);
    exp_t e;
    inValid = 1'b1; aluOp = op; srcA = a; srcB = b;
    WDIn = wd; RdIn = rd; memWriteIn = mw; memPixWriteIn = mpw;
    e.res = res; e.wd = wd; e.rd = rd; e.mw = mw; e.mpw = mpw;
    sb.push_back(e);
    cycle();
    inValid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]   op;
    logic [N-1:0] a, b, w;
    int           edges;
    bit           done;

    rst = 1'b1; inValid = 1'b0; aluOp = '0; srcA = '0; srcB = '0; WDIn = '0;
    RdIn = '0; memWriteIn = 1'b0; memPixWriteIn = 1'b0; memStall = 1'b0;
    cycle();
    cycle();
    chk("rst_out_valid", outValid, 0);
    chk("rst_alu_result", aluResult, 0);
    chk("rst_wd", WD, 0);
    chk("rst_rd", Rd, 0);
    chk("rst_mem_write", memWrite, 0);
    chk("rst_mem_pix_write", memPixWrite, 0);
    chk("rst_busy", busy, 0);
    memStall = 1'b1;
    #1;
    chk("rst_busy_follows_stall", busy, 1);
    memStall = 1'b0;
    rst = 1'b0;
    cycle();

    // Wrap-around add, then back-to-back shift and compare.
    issue(4'd0, 32'hFFFF_FFFF, 32'd1, 32'hA5A5_0001, 4'd3, 1'b1, 1'b0, 32'd0);
    chk("add_wrap_valid", out_seen, 1);
    issue(4'd7, 32'h8000_0000, 32'h24, 32'd7, 4'd4, 1'b0, 1'b1, 32'hF800_0000);
    chk("sra_valid", out_seen, 1);
    issue(4'd8, 32'hFFFF_FFFF, 32'd1, 32'd8, 4'd5, 1'b0, 1'b0, 32'd1);
    chk("slt_valid", out_seen, 1);

    for (int i = 0; i < 30; i++) begin
      op = 4'($urandom_range(0, 14));
      if (op >= 4'd10) op = op + 4'd1;
      a = $urandom(); b = $urandom(); w = $urandom();
      issue(op, a, b, w, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), model(op, a, b));
      chk("b2b_valid", out_seen, 1);
    end

    cycle();
    chk("idle_drops_valid", outValid, 0);

    // Multiply latency; a second request while busy must be dropped.
    issue(4'd10, 32'd7, 32'd6, 32'h0000_BEEF, 4'd5, 1'b1, 1'b0, 32'd42);
    chk("mul_accept_valid_low", outValid, 0);
    inValid = 1'b1; aluOp = 4'd0; srcA = 32'd100; srcB = 32'd1;
    done = 1'b0; edges = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (i == 8) inValid = 1'b0;
      cycle();
      if (out_seen) begin
        done = 1'b1;
        edges = i + 1;
      end else begin
        chk("mul_busy", busy, 1);
      end
    end
    chk("mul_done", done, 1);
    chk("mul_latency", edges, 33);
    chk("mul_idle_busy", busy, 0);
    cycle();

    // Multiply completing into a 5-cycle stall.
    issue(4'd10, 32'd7, 32'd6, 32'd1, 4'd9, 1'b0, 1'b1, 32'd42);
    for (int i = 0; i < 28; i++) begin
      cycle();
      chk("stall_mul_no_early_out", out_seen, 0);
    end
    memStall = 1'b1;
    for (int i = 0; i < 9; i++) begin
      cycle();
      chk("stall_mul_valid_low", outValid, 0);
      chk("stall_mul_busy", busy, 1);
    end
    memStall = 1'b0;
    cycle();
    chk("stall_mul_out", out_seen, 1);
    cycle();

    // Output register frozen under stall; inValid ignored.
    issue(4'd9, 32'd0, 32'h1234, 32'd2, 4'd6, 1'b0, 1'b0, 32'h1234);
    memStall = 1'b1;
    inValid = 1'b1; aluOp = 4'd0; srcA = 32'd5; srcB = 32'd5;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("freeze_valid", outValid, 1);
      chk("freeze_result", aluResult, 32'h1234);
      chk("freeze_busy", busy, 1);
    end
    memStall = 1'b0; inValid = 1'b0;
    cycle();
    chk("unfreeze_valid_low", outValid, 0);
    chk("unfreeze_result_hold", aluResult, 32'h1234);

    // Reset aborts a multiply in flight.
    issue(4'd10, 32'd9, 32'd9, 32'd3, 4'd7, 1'b1, 1'b1, 32'd81);
    for (int i = 0; i < 9; i++) cycle();
    rst = 1'b1;
    void'(sb.pop_back());
    cycle();
    chk("abort_valid", outValid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_result", aluResult, 0);
    rst = 1'b0;
    issue(4'd0, 32'd2, 32'd3, 32'd4, 4'd8, 1'b0, 1'b0, 32'd5);
    chk("post_abort_add", out_seen, 1);
    for (int i = 0; i < 40; i++) cycle();
    chk("scoreboard_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameter N, default 32, datapath width in bits.
REQ-002 Parameter RD_W, default 4, destination-register index width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 inValid  input  1  decode stage presents a valid operation.
REQ-006 aluOp  input  4  operation select (encoding in REQ-014).
REQ-007 srcA, srcB  input  N  operands.
REQ-008 WDIn  input  N  store data passed to memory stage.
REQ-009 RdIn  input  RD_W  destination register.
REQ-010 memWriteIn, memPixWriteIn  input  1  store flags passed downstream.
REQ-011 memStall  input  1  memory stage cannot accept; hold output register.
REQ-012 busy  output  1  upstream must hold its operation; = (state != IDLE) or memStall.
REQ-013 aluResult, WD (N), Rd (RD_W), memWrite, memPixWrite, outValid (1)  output  registered EX/MEM fields feeding the memory stage.

Function
REQ-014 aluOp: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, result 1/0), 9 PASSB, 10 MUL; 11-15 SHALL produce result 0.
REQ-015 ADD/SUB/MUL SHALL wrap modulo 2^N, no overflow flag; MUL returns the low N bits of the product.
REQ-016 Shift amount SHALL be srcB[$clog2(N)-1:0]; higher srcB bits are ignored.
REQ-017 Accept = inValid and not busy; inValid while busy SHALL be ignored and not latched.
REQ-018 FSM states IDLE, MUL, DONE.
REQ-019 IDLE, accept, aluOp != 10: at the next edge the output register SHALL load result, WDIn, RdIn, flags, and outValid = 1 (latency 1).
REQ-020 IDLE, accept, aluOp = 10: SHALL latch operands, RdIn, WDIn and flags, and go to MUL with counter = 0; output register unchanged except outValid = 0.
REQ-021 MUL: one shift-add step per cycle (multiplicand shifted left, multiplier shifted right, add when multiplier LSB = 1); after N steps SHALL go to DONE.
REQ-022 MUL SHALL keep stepping regardless of memStall.
REQ-023 DONE with memStall = 0: SHALL load the product and latched fields into the output register, set outValid = 1, and go to IDLE (total latency N+1 edges after accept).
REQ-024 DONE with memStall = 1: SHALL remain in DONE holding the product.
REQ-025 memStall = 1 in IDLE: output register including outValid SHALL hold; no accept.
REQ-026 IDLE, no accept, memStall = 0: outValid SHALL become 0 at the next edge; other output fields hold.
REQ-027 In back-to-back single-cycle operations with no stall, outputs SHALL update every cycle.

Reset
REQ-028 rst = 1 at an edge: state = IDLE, counter = 0, outValid = 0, memWrite = 0, memPixWrite = 0, aluResult = 0, WD = 0, Rd = 0.
REQ-029 rst during MUL or DONE SHALL abort the multiply with no output produced; rst has priority over every other input.
REQ-030 busy after reset SHALL equal memStall.

Verification
REQ-031 ADD 0xFFFFFFFF + 1, RdIn = 3 -> next edge aluResult = 0, Rd = 3, outValid = 1.
REQ-032 SRA 0x80000000 by srcB = 0x24 -> aluResult = 0xF8000000 (shift 4); SLT -1 < 1 -> 1.
REQ-033 MUL 7 x 6 -> busy = 1 for 32 cycles, aluResult = 42 and outValid = 1 exactly 33 edges after accept; a second inValid during busy is not accepted.
REQ-034 MUL completes with memStall = 1 for 5 cycles -> stays DONE, outValid stays 0, product 42 appears the edge after memStall drops.
REQ-035 memStall = 1 with outValid = 1 and aluResult = 0x1234 -> outputs frozen for the whole stall; inValid ignored.
REQ-036 rst asserted at cycle 10 of a MUL -> next edge state IDLE, outValid = 0, busy = 0; a fresh ADD is then accepted normally.
